// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_pkg
//  Description : Shared definitions for the data memory responder: funct3
//                access-size encodings, the response FSM state type and a
//                helper that flags misaligned accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // funct3 encodings (RISC-V load/store size and signedness)
   localparam logic [2:0] c_F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] c_F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] c_F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] c_F3_BU = 3'b100;   // LBU
   localparam logic [2:0] c_F3_HU = 3'b101;   // LHU

   // Response FSM: RESP is the cycle in which a read result is presented
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (f3)
         c_F3_H, c_F3_HU: mis = lane[0];
         c_F3_W:          mis = (lane != 2'b00);
         default:         mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : load_extract
//  Description : Combinational load alignment. Picks the addressed byte or
//                halfword out of a memory word, right-aligns it and sign- or
//                zero-extends it according to funct3. Unsupported funct3
//                values yield zero.
//  Ports       : word_i   - full memory word read at the word index
//                lane_i   - byte lane, addr[1:0]
//                funct3_i - access size/sign
//                result_o - right-aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_extract
   import mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        lane_i,
   input  logic [2:0]        funct3_i,
   output logic [DATA_W-1:0] result_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = word_i[7:0];
      case (lane_i)
         2'd0:    w_byte = word_i[7:0];
         2'd1:    w_byte = word_i[15:8];
         2'd2:    w_byte = word_i[23:16];
         default: w_byte = word_i[31:24];
      endcase
      // Alignment is enforced upstream, so only addr[1] picks the half.
      w_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      result_o = '0;
      case (funct3_i)
         c_F3_B:  result_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
         c_F3_BU: result_o = {{(DATA_W-8){1'b0}}, w_byte};
         c_F3_H:  result_o = {{(DATA_W-16){w_half[15]}}, w_half};
         c_F3_HU: result_o = {{(DATA_W-16){1'b0}}, w_half};
         c_F3_W:  result_o = word_i;
         default: result_o = '0;
      endcase
   end

endmodule : load_extract
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Byte-addressed data memory for a core load/store port.
//                Reads return one cycle after the request edge; stores
//                update only the addressed byte lanes. Illegal, misaligned
//                or conflicting (rd and wr together) requests do nothing
//                and raise a one-cycle err pulse; a rejected read still
//                produces a response with zero data.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous reset, active low
//                wr, rd   - store / load request, sampled at rising edge
//                addr     - byte address
//                wr_data  - right-aligned store data
//                funct3   - access size/sign
//                rd_data  - load result (valid while rd_valid)
//                rd_valid - high in the cycle after each read request
//                err      - one-cycle pulse for a rejected request
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [2:0]        funct3,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              err
);

   localparam int c_WORDS = 2 ** (ADDR_W - 2);

   // Storage: no reset, contents survive reset assertion.
   logic [DATA_W-1:0] mem_q [c_WORDS];

   state_e            state_q, state_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              err_q, err_d;

   logic [ADDR_W-3:0] w_idx;
   logic [1:0]        w_lane;
   logic              w_reject;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [DATA_W-1:0] w_ext;

   assign w_idx  = addr[ADDR_W-1:2];
   assign w_lane = addr[1:0];

   // funct3[2] set on a store means LBU/LHU/110/111: never a legal store.
   // 011/110/111 are illegal for either direction.
   always_comb begin
      w_reject = (wr & rd)
               | is_misaligned(funct3, w_lane)
               | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
               | (wr & funct3[2]);
   end

   assign w_wr_ok = wr & ~w_reject;
   assign w_rd_ok = rd & ~w_reject;

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = wr_data[31:0];
      case (funct3)
         c_F3_B: begin
            w_be[w_lane] = 1'b1;
            w_wdata      = {4{wr_data[7:0]}};
         end
         c_F3_H: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wr_data[15:0]}};
         end
         c_F3_W: begin
            w_be    = 4'b1111;
            w_wdata = wr_data[31:0];
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = wr_data[31:0];
         end
      endcase
   end

   // Reset gates the write so a request at a reset-held edge is ignored.
   always_ff @(posedge clk) begin
      if (reset && w_wr_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
         end
      end
   end

   load_extract #(
      .DATA_W (DATA_W)
   ) u_load_extract (
      .word_i   (mem_q[w_idx]),
      .lane_i   (w_lane),
      .funct3_i (funct3),
      .result_o (w_ext)
   );

   // Next-state and registered outputs. Any read (accepted or not) leads to
   // RESP; rejected reads return zero data.
   always_comb begin
      state_d   = ST_IDLE;
      rd_data_d = '0;
      err_d     = 1'b0;
      if (rd) begin
         state_d = ST_RESP;
      end
      if (w_rd_ok) begin
         rd_data_d = w_ext;
      end
      if ((wr | rd) && w_reject) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         rd_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = (state_q == ST_RESP);
   assign err      = err_q;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. A table of
//                directed requests with hand-computed responses is applied
//                one per cycle, followed by hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic              clk;
   logic              reset;
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              err;

   int n_checks;
   int n_fail;

   typedef struct {
      string       name;
      logic        wr;
      logic        rd;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vq[$];

   data_mem_responder #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr       (wr),
      .rd       (rd),
      .addr     (addr),
      .wr_data  (wr_data),
      .funct3   (funct3),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic w, input logic r,
                      input logic [8:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic ev,
                      input logic [31:0] ed, input logic ee);
      vec_t v;
      v.name = name; v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.f3 = f;
      v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
      vq.push_back(v);
   endtask

   task automatic drive(input logic w, input logic r, input logic [8:0] a,
                        input logic [31:0] d, input logic [2:0] f);
      wr = w; rd = r; addr = a; wr_data = d; funct3 = f;
   endtask

   task automatic check_outs(input string name, input logic ev,
                             input logic [31:0] ed, input logic ee);
      check({name, ".valid"}, {31'd0, rd_valid}, {31'd0, ev});
      check({name, ".data"},  rd_data, ed);
      check({name, ".err"},   {31'd0, err}, {31'd0, ee});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      drive(1'b0, 1'b0, 9'h000, 32'h0, LW);

      //                name        wr rd addr    wdata         f3   v  data          e
      add("sw_dead",    1, 0, 9'h010, 32'hDEADBEEF, LW,  0, 32'h00000000, 0);
      add("lw_dead",    0, 1, 9'h010, 32'h0,        LW,  1, 32'hDEADBEEF, 0);
      add("lb_013",     0, 1, 9'h013, 32'h0,        LB,  1, 32'hFFFFFFDE, 0);
      add("lbu_013",    0, 1, 9'h013, 32'h0,        LBU, 1, 32'h000000DE, 0);
      add("lh_012",     0, 1, 9'h012, 32'h0,        LH,  1, 32'hFFFFDEAD, 0);
      add("lhu_010",    0, 1, 9'h010, 32'h0,        LHU, 1, 32'h0000BEEF, 0);
      add("sb_011",     1, 0, 9'h011, 32'hFFFFFF55, LB,  0, 32'h00000000, 0);
      add("lw_sb",      0, 1, 9'h010, 32'h0,        LW,  1, 32'hDEAD55EF, 0);
      add("sh_012",     1, 0, 9'h012, 32'hABCD1234, LH,  0, 32'h00000000, 0);
      add("lw_sh",      0, 1, 9'h010, 32'h0,        LW,  1, 32'h123455EF, 0);
      add("lw_mis",     0, 1, 9'h012, 32'h0,        LW,  1, 32'h00000000, 1);
      add("sw_mis",     1, 0, 9'h011, 32'hFFFFFFFF, LW,  0, 32'h00000000, 1);
      add("lw_chk1",    0, 1, 9'h010, 32'h0,        LW,  1, 32'h123455EF, 0);
      add("rdwr",       1, 1, 9'h010, 32'h00000000, LW,  1, 32'h00000000, 1);
      add("lw_chk2",    0, 1, 9'h010, 32'h0,        LW,  1, 32'h123455EF, 0);
      add("f3_011",     0, 1, 9'h010, 32'h0,        3'b011, 1, 32'h00000000, 1);
      add("f3_110",     0, 1, 9'h010, 32'h0,        3'b110, 1, 32'h00000000, 1);
      add("sbu_ill",    1, 0, 9'h010, 32'h000000AA, LBU, 0, 32'h00000000, 1);
      add("shu_ill",    1, 0, 9'h010, 32'h0000AAAA, LHU, 0, 32'h00000000, 1);
      add("lw_chk3",    0, 1, 9'h010, 32'h0,        LW,  1, 32'h123455EF, 0);
      add("lh_mis",     0, 1, 9'h011, 32'h0,        LH,  1, 32'h00000000, 1);
      add("sh_mis",     1, 0, 9'h013, 32'h0000FFFF, LH,  0, 32'h00000000, 1);
      add("lb_010",     0, 1, 9'h010, 32'h0,        LB,  1, 32'hFFFFFFEF, 0);
      add("lb_011",     0, 1, 9'h011, 32'h0,        LB,  1, 32'h00000055, 0);
      add("idle",       0, 0, 9'h010, 32'h0,        LW,  0, 32'h00000000, 0);
      add("sw_top",     1, 0, 9'h1FC, 32'h80007F01, LW,  0, 32'h00000000, 0);
      add("sw_zero",    1, 0, 9'h000, 32'h11223344, LW,  0, 32'h00000000, 0);
      add("lw_top",     0, 1, 9'h1FC, 32'h0,        LW,  1, 32'h80007F01, 0);
      add("lb_1fc",     0, 1, 9'h1FC, 32'h0,        LB,  1, 32'h00000001, 0);
      add("lb_1fe",     0, 1, 9'h1FE, 32'h0,        LB,  1, 32'h00000000, 0);
      add("lh_1fe",     0, 1, 9'h1FE, 32'h0,        LH,  1, 32'hFFFF8000, 0);
      add("lhu_1fe",    0, 1, 9'h1FE, 32'h0,        LHU, 1, 32'h00008000, 0);
      add("lb_1fd",     0, 1, 9'h1FD, 32'h0,        LB,  1, 32'h0000007F, 0);
      add("lw_zero",    0, 1, 9'h000, 32'h0,        LW,  1, 32'h11223344, 0);
      add("sw_in_resp", 1, 0, 9'h004, 32'hCAFEF00D, LW,  0, 32'h00000000, 0);
      add("lw_new",     0, 1, 9'h004, 32'h0,        LW,  1, 32'hCAFEF00D, 0);
      add("idle2",      0, 0, 9'h000, 32'h0,        LW,  0, 32'h00000000, 0);

      // Reset state, checked before the first clock edge
      #2;
      check_outs("reset_state", 1'b0, 32'h0, 1'b0);

      repeat (2) @(negedge clk);
      reset = 1'b1;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].wr, vq[i].rd, vq[i].addr, vq[i].wdata, vq[i].f3);
         @(posedge clk);
         #1;
         check_outs(vq[i].name, vq[i].exp_valid, vq[i].exp_data, vq[i].exp_err);
      end

      // Reset asserted while a read response is being presented
      @(negedge clk);
      drive(1'b0, 1'b1, 9'h010, 32'h0, LW);
      @(posedge clk);
      #1;
      check_outs("pre_reset_lw", 1'b1, 32'h123455EF, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_outs("async_reset", 1'b0, 32'h0, 1'b0);

      // Requests at reset-held edges are ignored, including this store
      @(negedge clk);
      drive(1'b1, 1'b0, 9'h010, 32'h00000000, LW);
      @(posedge clk);
      #1;
      check_outs("reset_held_wr", 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b1, 9'h010, 32'h0, LW);
      @(posedge clk);
      #1;
      check_outs("reset_held_rd", 1'b0, 32'h0, 1'b0);

      // Release with no request: no stale response may appear
      @(negedge clk);
      drive(1'b0, 1'b0, 9'h010, 32'h0, LW);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_outs("post_release", 1'b0, 32'h0, 1'b0);

      // Memory survives reset
      @(negedge clk);
      drive(1'b0, 1'b1, 9'h010, 32'h0, LW);
      @(posedge clk);
      #1;
      check_outs("mem_retained", 1'b1, 32'h123455EF, 1'b0);

      @(negedge clk);
      drive(1'b0, 1'b0, 9'h000, 32'h0, LW);
      @(posedge clk);
      #1;
      check_outs("final_idle", 1'b0, 32'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_data_mem_responder
`default_nettype wire
